// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t        : arbiter FSM encoding (IDLE, GNT0, GNT1, ABORT)
//   TIMEOUT_CYCLES_DEF : default stall budget before a cycle is aborted
//   TIMER_W            : width of the stall timer (covers budgets up to 1023)
//   TCNT_W             : width of the saturating abort counter
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int TIMER_W            = 10;
  localparam int TCNT_W             = 8;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin grant decision (purely combinational).
//   req[1:0]   : request per master
//   last_grant : index of the master granted most recently
//   gnt[1:0]   : one-hot grant, all zero when nobody requests
// On a tie the master that was not granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Arbitrates two Wishbone masters (m0: host port, m1: key loader) onto one
// interconnect master port, with round-robin tie breaking and a stall timeout.
//   clk_i, rst          : clock, synchronous active-high reset
//   m0_wb_*, m1_wb_*    : master-side request inputs / response outputs
//   s_wb_*              : forwarded request / returned response
//   timeout_cnt_o       : saturating count of aborted cycles
// A granted master is connected combinationally to s_wb_*; the other master
// sees an all-zero response until it wins a later arbitration. A cycle that
// stalls for TIMEOUT_CYCLES strobe cycles without ack is aborted: the bus is
// released and the owner gets a one-cycle err in the first ABORT cycle.
// -----------------------------------------------------------------------------
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst,
  // master 0
  input  logic [31:0] m0_wb_dat_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  // master 1
  input  logic [31:0] m1_wb_dat_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  // interconnect side
  output logic [31:0] s_wb_dat_o,
  output logic [31:0] s_wb_adr_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  // status
  output logic [7:0]  timeout_cnt_o
);

  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

  arb_state_t          state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                err_pend_q, err_pend_d;   // set only for the first ABORT cycle
  logic                abort_mst_q, abort_mst_d; // master whose cycle was aborted

  logic [1:0] req;
  logic [1:0] gnt;
  logic       cur_mst;
  logic       cur_cyc;
  logic       cur_stb;

  assign req = {m1_wb_cyc_i & m1_wb_stb_i, m0_wb_cyc_i & m0_wb_stb_i};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    timer_d      = '0;
    tcnt_d       = tcnt_q;
    err_pend_d   = 1'b0;
    abort_mst_d  = abort_mst_q;
    cur_mst      = (state_q == GNT1);
    cur_cyc      = cur_mst ? m1_wb_cyc_i : m0_wb_cyc_i;
    cur_stb      = cur_mst ? m1_wb_stb_i : m0_wb_stb_i;

    unique case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          state_d = GNT0;
        end else if (gnt[1]) begin
          state_d = GNT1;
        end
      end

      GNT0, GNT1: begin
        if (!cur_cyc) begin
          state_d      = IDLE;
          last_grant_d = cur_mst;
        end else if (cur_stb && !s_wb_ack_i) begin
          // An ack in the expiry cycle keeps this branch from being taken,
          // so the completing transfer always beats the abort.
          if (timer_q == TIMER_LIMIT) begin
            state_d     = ABORT;
            err_pend_d  = 1'b1;
            abort_mst_d = cur_mst;
            if (tcnt_q != {TCNT_W{1'b1}}) begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      ABORT: begin
        // Wait for the aborted master to close its cycle before rearbitrating.
        if (!(abort_mst_q ? m1_wb_cyc_i : m0_wb_cyc_i)) begin
          state_d      = IDLE;
          last_grant_d = abort_mst_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      tcnt_q       <= '0;
      err_pend_q   <= 1'b0;
      abort_mst_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      tcnt_q       <= tcnt_d;
      err_pend_q   <= err_pend_d;
      abort_mst_q  <= abort_mst_d;
    end
  end

  // Output routing. Gating with rst keeps a slave ack that lands during a
  // reset cycle from reaching either master.
  always_comb begin
    s_wb_dat_o  = '0;
    s_wb_adr_o  = '0;
    s_wb_sel_o  = '0;
    s_wb_we_o   = 1'b0;
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    m0_wb_dat_o = '0;
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m1_wb_dat_o = '0;
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;

    if (!rst) begin
      unique case (state_q)
        GNT0: begin
          s_wb_dat_o  = m0_wb_dat_i;
          s_wb_adr_o  = m0_wb_adr_i;
          s_wb_sel_o  = m0_wb_sel_i;
          s_wb_we_o   = m0_wb_we_i;
          s_wb_cyc_o  = m0_wb_cyc_i;
          s_wb_stb_o  = m0_wb_stb_i;
          m0_wb_dat_o = s_wb_dat_i;
          m0_wb_ack_o = s_wb_ack_i;
        end
        GNT1: begin
          s_wb_dat_o  = m1_wb_dat_i;
          s_wb_adr_o  = m1_wb_adr_i;
          s_wb_sel_o  = m1_wb_sel_i;
          s_wb_we_o   = m1_wb_we_i;
          s_wb_cyc_o  = m1_wb_cyc_i;
          s_wb_stb_o  = m1_wb_stb_i;
          m1_wb_dat_o = s_wb_dat_i;
          m1_wb_ack_o = s_wb_ack_i;
        end
        ABORT: begin
          m0_wb_err_o = err_pend_q & ~abort_mst_q;
          m1_wb_err_o = err_pend_q &  abort_mst_q;
        end
        default: ;
      endcase
    end
  end

  assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter (TIMEOUT_CYCLES = 4). Stimulus pushes each
// expected master response into a scoreboard queue; a negedge monitor pops
// and compares whenever any master sees ack or err.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst;
  logic [31:0] m0_wb_dat_i, m0_wb_adr_i, m0_wb_dat_o;
  logic [3:0]  m0_wb_sel_i;
  logic        m0_wb_we_i, m0_wb_cyc_i, m0_wb_stb_i, m0_wb_ack_o, m0_wb_err_o;
  logic [31:0] m1_wb_dat_i, m1_wb_adr_i, m1_wb_dat_o;
  logic [3:0]  m1_wb_sel_i;
  logic        m1_wb_we_i, m1_wb_cyc_i, m1_wb_stb_i, m1_wb_ack_o, m1_wb_err_o;
  logic [31:0] s_wb_dat_o, s_wb_adr_o, s_wb_dat_i;
  logic [3:0]  s_wb_sel_o;
  logic        s_wb_we_o, s_wb_cyc_o, s_wb_stb_o, s_wb_ack_i;
  logic [7:0]  timeout_cnt_o;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst(rst),
    .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_sel_i(m0_wb_sel_i),
    .m0_wb_we_i(m0_wb_we_i), .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i),
    .m0_wb_dat_o(m0_wb_dat_o), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
    .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_sel_i(m1_wb_sel_i),
    .m1_wb_we_i(m1_wb_we_i), .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i),
    .m1_wb_dat_o(m1_wb_dat_o), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o),
    .s_wb_dat_o(s_wb_dat_o), .s_wb_adr_o(s_wb_adr_o), .s_wb_sel_o(s_wb_sel_o),
    .s_wb_we_o(s_wb_we_o), .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i),
    .timeout_cnt_o(timeout_cnt_o)
  );

  typedef struct {
    bit          mst;
    bit          err;
    logic [31:0] dat;
    logic [7:0]  tcnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input bit mst, input bit err, input logic [31:0] dat, input logic [7:0] tcnt);
    exp_t e;
    e.mst = mst; e.err = err; e.dat = dat; e.tcnt = tcnt;
    sb_q.push_back(e);
  endtask

  // Response monitor
  always @(negedge clk_i) begin
    exp_t e;
    if ((m0_wb_ack_o | m0_wb_err_o | m1_wb_ack_o | m1_wb_err_o) === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got m0 ack/err=%b%b m1 ack/err=%b%b expected none",
                 m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o);
      end else begin
        e = sb_q.pop_front();
        chk("resp_flags", 32'({m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o}),
            32'({!e.mst && !e.err, !e.mst && e.err, e.mst && !e.err, e.mst && e.err}));
        if (!e.err) chk("resp_dat", e.mst ? m1_wb_dat_o : m0_wb_dat_o, e.dat);
        else        chk("resp_tcnt", 32'(timeout_cnt_o), 32'(e.tcnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ctl"}, 32'({s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o}), 32'd0);
    chk({tag, "_s_adr"}, s_wb_adr_o, 32'd0);
    chk({tag, "_s_dat"}, s_wb_dat_o, 32'd0);
    chk({tag, "_m_dat"}, m0_wb_dat_o | m1_wb_dat_o, 32'd0);
    chk({tag, "_m_ackerr"}, 32'({m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o}), 32'd0);
    chk({tag, "_tcnt"}, 32'(timeout_cnt_o), 32'd0);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  task automatic req0(input logic [31:0] adr, input logic on);
    m0_wb_adr_i = adr; m0_wb_dat_i = ~adr; m0_wb_sel_i = 4'hF; m0_wb_we_i = 1'b0;
    m0_wb_cyc_i = on; m0_wb_stb_i = on;
  endtask

  task automatic req1(input logic [31:0] adr, input logic on);
    m1_wb_adr_i = adr; m1_wb_dat_i = ~adr; m1_wb_sel_i = 4'h3; m1_wb_we_i = 1'b1;
    m1_wb_cyc_i = on; m1_wb_stb_i = on;
  endtask

  // One tie round: both request, the expected winner gets a zero-wait ack.
  task automatic tie_round(input int r);
    bit          exp_mst;
    logic [31:0] a0, a1, d;
    exp_mst = bit'(r % 2);
    a0 = 32'h4000_0000 | 32'(r);
    a1 = 32'h5000_0000 | 32'(r);
    d  = 32'h7700_0000 | 32'(r);
    req0(a0, 1'b1);
    req1(a1, 1'b1);
    tick();
    chk($sformatf("t3_round%0d_grant_adr", r), s_wb_adr_o, exp_mst ? a1 : a0);
    s_wb_ack_i = 1'b1; s_wb_dat_i = d;
    push(exp_mst, 1'b0, d, 8'd0);
    tick();
    s_wb_ack_i = 1'b0;
    req0(a0, 1'b0);
    req1(a1, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req0(32'd0, 1'b0);
    req1(32'd0, 1'b0);
    s_wb_ack_i = 1'b0;
    s_wb_dat_i = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk_all_zero("reset");

    // Single m0 read at 0x1004, slave acks after two wait cycles
    tick();
    req0(32'h0000_1004, 1'b1);
    settle();
    chk("t1_idle_s_cyc", 32'(s_wb_cyc_o), 32'd0);
    tick();
    chk("t1_gnt_s_ctl", 32'({s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o}), 32'b1101111);
    chk("t1_gnt_s_adr", s_wb_adr_o, 32'h0000_1004);
    chk("t1_m1_quiet", 32'({m1_wb_ack_o, m1_wb_err_o}) | m1_wb_dat_o, 32'd0);
    tick();
    chk("t1_wait_m0_ack", 32'(m0_wb_ack_o), 32'd0);
    tick();
    s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hCAFE_0001;
    push(1'b0, 1'b0, 32'hCAFE_0001, 8'd0);
    settle();
    chk("t1_m1_quiet_ack", 32'({m1_wb_ack_o, m1_wb_err_o}) | m1_wb_dat_o, 32'd0);
    tick();
    s_wb_ack_i = 1'b0;
    req0(32'h0000_1004, 1'b0);
    settle();
    chk("t1_ack_single", 32'(m0_wb_ack_o), 32'd0);
    tick();
    chk("t1_release_s_cyc", 32'(s_wb_cyc_o), 32'd0);

    // Simultaneous requests straight after reset: m0 first, then m1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0(32'h0000_2000, 1'b1);
    req1(32'h0000_3000, 1'b1);
    tick();
    chk("t2_first_adr", s_wb_adr_o, 32'h0000_2000);
    s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hA5A5_0000;
    push(1'b0, 1'b0, 32'hA5A5_0000, 8'd0);
    settle();
    chk("t2_m1_held", 32'({m1_wb_ack_o, m1_wb_err_o}) | m1_wb_dat_o, 32'd0);
    tick();
    s_wb_ack_i = 1'b0;
    req0(32'h0000_2000, 1'b0);
    tick();
    chk("t2_gap_s_cyc", 32'(s_wb_cyc_o), 32'd0);
    tick();
    chk("t2_second_cyc", 32'(s_wb_cyc_o), 32'd1);
    chk("t2_second_adr", s_wb_adr_o, 32'h0000_3000);
    s_wb_ack_i = 1'b1; s_wb_dat_i = 32'h5A5A_1111;
    push(1'b1, 1'b0, 32'h5A5A_1111, 8'd0);
    tick();
    s_wb_ack_i = 1'b0;
    req1(32'h0000_3000, 1'b0);
    tick();

    // Repeated ties alternate starting with m0
    for (int r = 0; r < 8; r++) tie_round(r);

    // Timeout: slave never acks
    req0(32'h0000_6000, 1'b1);
    tick();
    chk("t4_stall1_cyc", 32'(s_wb_cyc_o), 32'd1);
    tick();
    tick();
    tick();
    chk("t4_stall4_cyc", 32'(s_wb_cyc_o), 32'd1);
    push(1'b0, 1'b1, 32'd0, 8'd1);
    tick();
    chk("t4_abort_s_cycstb", 32'({s_wb_cyc_o, s_wb_stb_o}), 32'd0);
    chk("t4_abort_tcnt", 32'(timeout_cnt_o), 32'd1);
    tick();
    chk("t4_abort2_s_cyc", 32'(s_wb_cyc_o), 32'd0);
    req0(32'h0000_6000, 1'b0);
    tick();
    chk("t4_back_idle", 32'(dut.state_q), 32'(IDLE));

    // Ack lands in the cycle the timer would expire
    req0(32'h0000_7000, 1'b1);
    tick();
    tick();
    tick();
    tick();
    s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hD00D_0004;
    push(1'b0, 1'b0, 32'hD00D_0004, 8'd1);
    tick();
    s_wb_ack_i = 1'b0;
    req0(32'h0000_7000, 1'b0);
    settle();
    chk("t5_no_abort_state", 32'(dut.state_q), 32'(GNT0));
    chk("t5_tcnt_kept", 32'(timeout_cnt_o), 32'd1);
    tick();

    // Reset during an m1 wait state, slave acking inside the reset cycle
    req1(32'h0000_8000, 1'b1);
    tick();
    chk("t6_gnt1_cyc", 32'(s_wb_cyc_o), 32'd1);
    tick();
    rst = 1'b1;
    s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hDEAD_0000;
    tick();
    rst = 1'b0;
    s_wb_ack_i = 1'b0;
    req1(32'h0000_8000, 1'b0);
    settle();
    chk_all_zero("t6_post_rst");
    tick();
    req1(32'h0000_9000, 1'b1);
    tick();
    chk("t6_regrant_adr", s_wb_adr_o, 32'h0000_9000);
    s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hBEEF_0009;
    push(1'b1, 1'b0, 32'hBEEF_0009, 8'd0);
    tick();
    s_wb_ack_i = 1'b0;
    req1(32'h0000_9000, 1'b0);
    tick();
    tick();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
